// File: rtl/fetch_if.sv
// Bus bundle between the fetch unit, instruction memory, execute (redirect) and the decoder.
interface fetch_if #(
   parameter int XLEN = 32
);
   logic            o_imem_req_valid;
   logic            i_imem_req_ready;
   logic [XLEN-1:0] o_imem_addr;
   logic            i_imem_rsp_valid;
   logic [XLEN-1:0] i_imem_rsp_data;
   logic            i_redirect_valid;
   logic [XLEN-1:0] i_redirect_pc;
   logic            o_instr_valid;
   logic            i_instr_ready;
   logic [XLEN-1:0] o_instruction;
   logic [XLEN-1:0] o_pc;

   modport master (
      output o_imem_req_valid, o_imem_addr, o_instr_valid, o_instruction, o_pc,
      input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
             i_redirect_valid, i_redirect_pc, i_instr_ready
   );

   modport slave (
      input  o_imem_req_valid, o_imem_addr, o_instr_valid, o_instruction, o_pc,
      output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
             i_redirect_valid, i_redirect_pc, i_instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order word fetch, PC-tagged buffer FIFO,
// and redirect flush that drops responses still in flight.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input logic     i_clk,
   input logic     i_rst_n,
   fetch_if.master bus
);
   localparam int              PW      = $clog2(FIFO_DEPTH);
   localparam int              CW      = PW + 1;
   localparam logic [XLEN-1:0] STEP    = XLEN'(4);
   localparam logic [CW:0]     DEPTH_W = (CW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

   logic            run_q, run_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [XLEN-1:0] pc_mem_q [FIFO_DEPTH];
   logic [XLEN-1:0] pc_mem_d [FIFO_DEPTH];
   logic [XLEN-1:0] data_mem_q [FIFO_DEPTH];
   logic [XLEN-1:0] data_mem_d [FIFO_DEPTH];

   logic            req_valid, req_fire, rsp_take, push, pop, instr_valid;
   logic [CW:0]     credit_used;
   logic [XLEN-1:0] redirect_tgt;
   logic [1:0]      unused_redirect_lsb;

   assign unused_redirect_lsb = bus.i_redirect_pc[1:0];
   assign redirect_tgt        = {bus.i_redirect_pc[XLEN-1:2], 2'b00};

   // Buffered entries plus in-flight responses never exceed the FIFO depth, so every
   // response that is kept always has a free slot waiting for it.
   always_comb begin
      credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
      instr_valid = (count_q != '0);
      req_valid   = run_q && !bus.i_redirect_valid && (credit_used < DEPTH_W);
      req_fire    = req_valid && bus.i_imem_req_ready;
      rsp_take    = bus.i_imem_rsp_valid && (outstanding_q != '0);
      pop         = instr_valid && bus.i_instr_ready;
      push        = rsp_take && (drop_q == '0) && !bus.i_redirect_valid;
   end

   always_comb begin
      run_d         = 1'b1;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      pc_mem_d      = pc_mem_q;
      data_mem_d    = data_mem_q;
      if (bus.i_redirect_valid) begin
         fetch_pc_d    = redirect_tgt;
         rsp_pc_d      = redirect_tgt;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
         outstanding_d = outstanding_q - CW'(rsp_take);
         drop_d        = outstanding_d;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + STEP;
         end
         outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
         if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (push) begin
            pc_mem_d[wr_ptr_q]   = rsp_pc_q;
            data_mem_d[wr_ptr_q] = bus.i_imem_rsp_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
            rsp_pc_d             = rsp_pc_q + STEP;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_q         <= 1'b0;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         pc_mem_q      <= '{default: '0};
         data_mem_q    <= '{default: '0};
      end else begin
         run_q         <= run_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         pc_mem_q      <= pc_mem_d;
         data_mem_q    <= data_mem_d;
      end
   end

   assign bus.o_imem_req_valid = req_valid;
   assign bus.o_imem_addr      = fetch_pc_q;
   assign bus.o_instr_valid    = instr_valid;
   assign bus.o_instruction    = instr_valid ? data_mem_q[rd_ptr_q] : '0;
   assign bus.o_pc             = instr_valid ? pc_mem_q[rd_ptr_q] : '0;

   a_rsp_has_credit: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      bus.i_imem_rsp_valid |-> (outstanding_q != '0));

   a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      push |-> ((count_q != DEPTH_C) || pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with in-order latency, expected-stream scoreboard,
// directed corner cases followed by a randomized run.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fetch_if #(.XLEN(32)) bus ();

   fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          pops     = 0;
   int          lat_min  = 1;
   int          lat_max  = 1;
   int          last_due = 0;
   logic [31:0] mask     = 32'h0;
   logic [31:0] exp_req  = RESET_PC;
   logic [31:0] exp_pc   = RESET_PC;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] seg_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Instruction memory: in-order responses, data = addr ^ mask, also checks request addresses.
   initial begin
      int lat, due;
      bus.i_imem_rsp_valid = 1'b0;
      bus.i_imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.i_imem_rsp_valid = 1'b0;
         if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            last_due = 0;
         end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.i_imem_rsp_valid = 1'b1;
            bus.i_imem_rsp_data  = pend_addr.pop_front() ^ mask;
            void'(pend_due.pop_front());
         end
         #4;
         if (!rst_n) begin
            exp_req = RESET_PC;
         end else begin
            if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
               chk("req_addr", bus.o_imem_addr, exp_req);
               lat = int'($urandom_range(lat_max, lat_min));
               due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
               last_due = due;
               pend_addr.push_back(bus.o_imem_addr);
               pend_due.push_back(due);
               exp_req = exp_req + 32'd4;
            end
            if (bus.i_redirect_valid) begin
               chk("req_in_redirect", 32'(bus.o_imem_req_valid), 32'd0);
               exp_req = bus.i_redirect_pc & 32'hFFFF_FFFC;
            end
         end
      end
   end

   // Scoreboard monitor: output stream must be consecutive PCs from the last restart point.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            exp_pc = RESET_PC;
         end else begin
            if (bus.o_instr_valid && bus.i_instr_ready) begin
               chk("out_pc", bus.o_pc, exp_pc);
               chk("out_data", bus.o_instruction, exp_pc ^ mask);
               exp_pc = exp_pc + 32'd4;
               pops++;
            end
            if (bus.i_redirect_valid) begin
               chk("redirect_queued", 32'(seg_q.size() != 0), 32'd1);
               if (seg_q.size() != 0) exp_pc = seg_q.pop_front() & 32'hFFFF_FFFC;
            end
         end
      end
   end

   task automatic do_reset(input int new_lat_min, input int new_lat_max, input logic [31:0] new_mask);
      @(negedge clk);
      rst_n = 1'b0;
      bus.i_redirect_valid = 1'b0;
      lat_min = new_lat_min;
      lat_max = new_lat_max;
      mask = new_mask;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called at a negedge; leaves at the negedge of the following cycle with redirect dropped.
   task automatic redirect(input logic [31:0] tgt);
      seg_q.push_back(tgt);
      bus.i_redirect_pc    = tgt;
      bus.i_redirect_valid = 1'b1;
      @(negedge clk);
      bus.i_redirect_valid = 1'b0;
   endtask

   // Called at a negedge; waits for the next request fire and checks its address.
   task automatic expect_fire(input string name, input logic [31:0] addr);
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         #4;
         if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
            found = 1;
            chk(name, bus.o_imem_addr, addr);
         end
         @(negedge clk);
      end
      chk({name, "_seen"}, 32'(found), 32'd1);
   endtask

   // Called at a negedge; waits for the next valid instruction and checks pc and data.
   task automatic expect_out(input string name, input logic [31:0] pc);
      bit found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         #4;
         if (bus.o_instr_valid) begin
            found = 1;
            chk({name, "_pc"}, bus.o_pc, pc);
            chk({name, "_data"}, bus.o_instruction, pc ^ mask);
         end
         @(negedge clk);
      end
      chk({name, "_seen"}, 32'(found), 32'd1);
   endtask

   initial begin
      int c0, cv, clast, nv, nf, pops0;
      bus.i_imem_req_ready = 1'b1;
      bus.i_redirect_valid = 1'b0;
      bus.i_redirect_pc    = '0;
      bus.i_instr_ready    = 1'b1;

      #2;
      chk("rst_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(bus.o_instr_valid), 32'd0);
      chk("rst_instruction", bus.o_instruction, 32'd0);
      chk("rst_pc", bus.o_pc, 32'd0);

      // Streaming with 1-cycle memory, data == address.
      do_reset(1, 1, 32'h0);
      c0 = -1; cv = -1; clast = -1; nv = 0;
      for (int i = 0; i < 12; i++) begin
         #4;
         if (c0 < 0 && bus.o_imem_req_valid && bus.i_imem_req_ready) c0 = i;
         if (bus.o_instr_valid && nv < 4) begin
            if (cv < 0) cv = i;
            clast = i;
            chk("t1_pc", bus.o_pc, 32'(nv * 4));
            chk("t1_instr", bus.o_instruction, 32'(nv * 4));
            nv++;
         end
         @(negedge clk);
      end
      chk("t1_latency", 32'(cv - c0), 32'd2);
      chk("t1_consecutive", 32'(clast - cv), 32'd3);

      // Downstream stalled: exactly four requests, then backpressure.
      bus.i_instr_ready = 1'b0;
      do_reset(1, 1, 32'h0);
      nf = 0;
      for (int i = 0; i < 12; i++) begin
         #4;
         if (bus.o_imem_req_valid && bus.i_imem_req_ready) nf++;
         @(negedge clk);
      end
      #4;
      chk("t2_fires", 32'(nf), 32'd4);
      chk("t2_req_off", 32'(bus.o_imem_req_valid), 32'd0);
      chk("t2_full_valid", 32'(bus.o_instr_valid), 32'd1);
      chk("t2_head_pc", bus.o_pc, 32'h0);
      @(negedge clk);
      bus.i_instr_ready = 1'b1;
      expect_fire("t2_resume_addr", 32'h10);
      repeat (10) @(negedge clk);

      // 3-cycle memory, redirect with three requests in flight.
      do_reset(3, 3, 32'h5A5A_0F0F);
      nf = 0;
      for (int i = 0; i < 12 && nf < 3; i++) begin
         #4;
         if (bus.o_imem_req_valid && bus.i_imem_req_ready) nf++;
         @(negedge clk);
      end
      chk("t3_in_flight", 32'(nf), 32'd3);
      redirect(32'h100);
      expect_out("t3_first", 32'h100);
      repeat (5) @(negedge clk);

      // Unaligned redirect target.
      redirect(32'h203);
      expect_fire("t4_addr", 32'h200);
      expect_out("t4_first", 32'h200);
      repeat (5) @(negedge clk);

      // Address wrap.
      redirect(32'hFFFF_FFF8);
      expect_fire("t5_addr0", 32'hFFFF_FFF8);
      expect_fire("t5_addr1", 32'hFFFF_FFFC);
      expect_fire("t5_wrap", 32'h0000_0000);
      repeat (20) @(negedge clk);

      // Reset mid-stream with two buffered entries and one response outstanding.
      bus.i_instr_ready = 1'b0;
      do_reset(2, 2, 32'h1111_2222);
      nf = 0;
      for (int i = 0; i < 12 && nf < 3; i++) begin
         #4;
         if (bus.o_imem_req_valid && bus.i_imem_req_ready) nf++;
         @(negedge clk);
      end
      bus.i_imem_req_ready = 1'b0;
      #4;
      chk("t6_pre_valid", 32'(bus.o_instr_valid), 32'd1);
      chk("t6_pre_data", bus.o_instruction, 32'h1111_2222);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
      chk("t6_rst_instr_valid", 32'(bus.o_instr_valid), 32'd0);
      chk("t6_rst_instruction", bus.o_instruction, 32'd0);
      chk("t6_rst_pc", bus.o_pc, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bus.i_imem_req_ready = 1'b1;
      bus.i_instr_ready = 1'b1;
      expect_fire("t6_first_addr", RESET_PC);

      // Redirect coinciding with the first response while the FIFO is empty.
      #4;
      chk("t7_empty", 32'(bus.o_instr_valid), 32'd0);
      @(negedge clk);
      redirect(32'h40);
      expect_out("t7_first", 32'h40);

      // Randomized run.
      do_reset(1, 4, 32'hC0DE_F00D);
      pops0 = pops;
      for (int i = 0; i < 3000; i++) begin
         bus.i_imem_req_ready = ($urandom_range(3, 0) != 0);
         bus.i_instr_ready    = ($urandom_range(9, 0) < 7);
         if ($urandom_range(24, 0) == 0) begin
            bus.i_redirect_pc = $urandom();
            seg_q.push_back(bus.i_redirect_pc);
            bus.i_redirect_valid = 1'b1;
         end else begin
            bus.i_redirect_valid = 1'b0;
         end
         @(negedge clk);
      end
      bus.i_redirect_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("rand_progress", 32'(pops - pops0 > 300), 32'd1);
      chk("seg_q_drained", 32'(seg_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
